// File: rtl/cpu_writeback_queue.sv
// Writeback queue between the memory stage and the register file: captures tagged results
// into a small FIFO, drains one per cycle into registered outputs and serves rs forwarding.
module cpu_writeback_queue #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int REG_W   = 5,
    parameter int TAG_W   = 8,
    parameter int DEPTH   = 4,
    parameter bit DROP_X0 = 1'b1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [TAG_W-1:0]          i_tag,
    input  logic [REG_W-1:0]          i_inst_rd,
    input  logic [DATA_W-1:0]         i_rd,
    input  logic                      i_branch,
    input  logic [PC_W-1:0]           i_pc_next,
    input  logic                      i_stall,
    input  logic [REG_W-1:0]          i_fwd_rs,
    output logic                      o_full,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_fwd_hit,
    output logic [DATA_W-1:0]         o_fwd_data,
    output logic [TAG_W-1:0]          o_tag,
    output logic [REG_W-1:0]          o_inst_rd,
    output logic [DATA_W-1:0]         o_rd,
    output logic                      o_branch,
    output logic [PC_W-1:0]           o_pc_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is a flat register array: forwarding has to look at every slot at once.
    logic [TAG_W-1:0]  tag_mem    [DEPTH];
    logic [REG_W-1:0]  rd_idx_mem [DEPTH];
    logic [DATA_W-1:0] data_mem   [DEPTH];
    logic              branch_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem     [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [TAG_W-1:0] last_tag_reg;
    logic             out_valid_reg;

    logic is_new;
    logic is_drop;
    logic is_empty;
    logic is_full;
    logic can_take;
    logic bypass;
    logic pop;
    logic accept;
    logic push;

    assign is_new   = (i_tag != last_tag_reg);
    assign is_drop  = DROP_X0 && is_new && (i_inst_rd == '0) && !i_branch;
    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == CNT_W'(DEPTH));
    assign can_take = is_new && !is_drop;
    // An empty queue hands a fresh item straight to the outputs without using a slot.
    assign bypass   = can_take && is_empty && !i_stall;
    assign pop      = !is_empty && !i_stall;
    assign accept   = can_take && (!is_full || pop);
    assign push     = accept && !bypass;

    assign o_full  = is_full && i_stall;
    assign o_count = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            last_tag_reg  <= '0;
            out_valid_reg <= 1'b0;
            o_tag         <= '0;
            o_inst_rd     <= '0;
            o_rd          <= '0;
            o_branch      <= 1'b0;
            o_pc_next     <= '0;
        end else begin
            count_reg <= count_next;
            if (accept || is_drop) begin
                last_tag_reg <= i_tag;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                out_valid_reg <= 1'b1;
                o_tag         <= tag_mem[rd_ptr_reg];
                o_inst_rd     <= rd_idx_mem[rd_ptr_reg];
                o_rd          <= data_mem[rd_ptr_reg];
                o_branch      <= branch_mem[rd_ptr_reg];
                o_pc_next     <= pc_mem[rd_ptr_reg];
            end else if (bypass) begin
                out_valid_reg <= 1'b1;
                o_tag         <= i_tag;
                o_inst_rd     <= i_inst_rd;
                o_rd          <= i_rd;
                o_branch      <= i_branch;
                o_pc_next     <= i_pc_next;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            tag_mem[wr_ptr_reg]    <= i_tag;
            rd_idx_mem[wr_ptr_reg] <= i_inst_rd;
            data_mem[wr_ptr_reg]   <= i_rd;
            branch_mem[wr_ptr_reg] <= i_branch;
            pc_mem[wr_ptr_reg]     <= i_pc_next;
        end
    end

    // Slot gi is the gi-th oldest pending entry; higher gi means newer.
    logic [DEPTH-1:0] slot_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] slot_idx;
            assign slot_idx     = rd_ptr_reg + PTR_W'(gi);
            assign slot_hit[gi] = (CNT_W'(gi) < count_reg) && (rd_idx_mem[slot_idx] == i_fwd_rs);
        end
    endgenerate

    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        if (out_valid_reg && (o_inst_rd == i_fwd_rs)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = o_rd;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_hit[i]) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = data_mem[rd_ptr_reg + PTR_W'(i)];
            end
        end
        if (i_fwd_rs == '0) begin
            o_fwd_hit  = 1'b0;
            o_fwd_data = '0;
        end
    end

endmodule

// File: tb/tb_cpu_writeback_queue.sv
// Self-checking bench for cpu_writeback_queue: vector table plus drain scoreboard,
// followed by forwarding, held-tag and asynchronous-reset sequences.
module tb_cpu_writeback_queue;

    logic        i_clock;
    logic        i_reset;
    logic [7:0]  i_tag;
    logic [4:0]  i_inst_rd;
    logic [31:0] i_rd;
    logic        i_branch;
    logic [31:0] i_pc_next;
    logic        i_stall;
    logic [4:0]  i_fwd_rs;
    logic        o_full;
    logic [2:0]  o_count;
    logic        o_fwd_hit;
    logic [31:0] o_fwd_data;
    logic [7:0]  o_tag;
    logic [4:0]  o_inst_rd;
    logic [31:0] o_rd;
    logic        o_branch;
    logic [31:0] o_pc_next;

    cpu_writeback_queue #(
        .DATA_W(32), .PC_W(32), .REG_W(5), .TAG_W(8), .DEPTH(4), .DROP_X0(1'b1)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_tag(i_tag), .i_inst_rd(i_inst_rd),
        .i_rd(i_rd), .i_branch(i_branch), .i_pc_next(i_pc_next), .i_stall(i_stall),
        .i_fwd_rs(i_fwd_rs), .o_full(o_full), .o_count(o_count), .o_fwd_hit(o_fwd_hit),
        .o_fwd_data(o_fwd_data), .o_tag(o_tag), .o_inst_rd(o_inst_rd), .o_rd(o_rd),
        .o_branch(o_branch), .o_pc_next(o_pc_next)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [7:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        br;
        logic [31:0] pc;
    } item_t;

    typedef struct {
        logic [7:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        br;
        logic        stall;
        logic        exp_full;
        int          exp_count;
    } vec_t;

    item_t sb[$];
    vec_t  vecs[17];
    int    checks;
    int    errors;
    int    drains;
    int    d0;
    logic [7:0] prev_tag;
    logic [7:0] model_last_tag;
    logic       full_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        item_t e;
        if (o_tag != prev_tag) begin
            drains++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_drain actual=%0h required=none", o_tag);
            end else begin
                e = sb.pop_front();
                check("drain_tag", o_tag, e.tag);
                check("drain_inst_rd", o_inst_rd, e.rd);
                check("drain_rd", o_rd, e.val);
                check("drain_branch", o_branch, e.br);
                check("drain_pc_next", o_pc_next, e.pc);
            end
            $display("drain tag=%0d rd=%0d val=%0h br=%0b pc=%0h count=%0d",
                     o_tag, o_inst_rd, o_rd, o_branch, o_pc_next, o_count);
            prev_tag = o_tag;
        end
    endtask

    // Drive one cycle of stimulus; predicted accepts are queued before the edge.
    task automatic step(input logic [7:0] tag, input logic [4:0] rd, input logic [31:0] val,
                        input logic br, input logic stall, output logic fs);
        item_t e;
        i_tag     = tag;
        i_inst_rd = rd;
        i_rd      = val;
        i_branch  = br;
        i_pc_next = 32'h1000 + {22'h0, tag, 2'b00};
        i_stall   = stall;
        #1;
        fs = o_full;
        if (tag != model_last_tag) begin
            if (rd == 5'd0 && !br) begin
                model_last_tag = tag;
            end else if (!o_full) begin
                e.tag = tag; e.rd = rd; e.val = val; e.br = br; e.pc = i_pc_next;
                sb.push_back(e);
                model_last_tag = tag;
            end
        end
        @(posedge i_clock);
        #1;
        monitor();
    endtask

    task automatic fwd_check(input logic [4:0] rs, input logic exp_hit, input logic [31:0] exp_data);
        i_fwd_rs = rs;
        #1;
        check($sformatf("fwd_hit_rs%0d", rs), o_fwd_hit, exp_hit);
        check($sformatf("fwd_data_rs%0d", rs), o_fwd_data, exp_data);
        $display("fwd rs=%0d hit=%0b data=%0h", rs, o_fwd_hit, o_fwd_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; drains = 0;
        prev_tag = 8'd0; model_last_tag = 8'd0;
        i_reset = 1'b0; i_tag = 8'd0; i_inst_rd = 5'd0; i_rd = 32'd0; i_branch = 1'b0;
        i_pc_next = 32'd0; i_stall = 1'b0; i_fwd_rs = 5'd0;

        //             tag    rd    val          br    stall full  count
        vecs[0]  = '{8'd1, 5'd5, 32'hDEAD,  1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{8'd1, 5'd5, 32'hDEAD,  1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{8'd2, 5'd0, 32'h102,   1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{8'd3, 5'd0, 32'h103,   1'b1, 1'b0, 1'b0, 0};
        vecs[4]  = '{8'd4, 5'd1, 32'h104,   1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{8'd5, 5'd2, 32'h105,   1'b0, 1'b1, 1'b0, 2};
        vecs[6]  = '{8'd6, 5'd3, 32'h106,   1'b1, 1'b1, 1'b0, 3};
        vecs[7]  = '{8'd7, 5'd4, 32'h107,   1'b0, 1'b1, 1'b0, 4};
        vecs[8]  = '{8'd8, 5'd5, 32'h108,   1'b0, 1'b1, 1'b1, 4};
        vecs[9]  = '{8'd8, 5'd5, 32'h108,   1'b0, 1'b1, 1'b1, 4};
        vecs[10] = '{8'd8, 5'd5, 32'h108,   1'b0, 1'b0, 1'b0, 4};
        vecs[11] = '{8'd8, 5'd5, 32'h108,   1'b0, 1'b0, 1'b0, 3};
        vecs[12] = '{8'd9, 5'd6, 32'h109,   1'b0, 1'b0, 1'b0, 3};
        vecs[13] = '{8'd9, 5'd6, 32'h109,   1'b0, 1'b0, 1'b0, 2};
        vecs[14] = '{8'd9, 5'd6, 32'h109,   1'b0, 1'b0, 1'b0, 1};
        vecs[15] = '{8'd9, 5'd6, 32'h109,   1'b0, 1'b0, 1'b0, 0};
        vecs[16] = '{8'd9, 5'd6, 32'h109,   1'b0, 1'b0, 1'b0, 0};

        #23;
        check("reset_count", o_count, 0);
        check("reset_tag", o_tag, 0);
        check("reset_rd", o_rd, 0);
        check("reset_full", o_full, 0);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].tag, vecs[i].rd, vecs[i].val, vecs[i].br, vecs[i].stall, full_seen);
            check($sformatf("row%0d_full", i), full_seen, vecs[i].exp_full);
            check($sformatf("row%0d_count", i), o_count, vecs[i].exp_count);
            if (i == 0) check("bypass_latency_tag", o_tag, 1);
            if (i == 10) check("release_first_tag", o_tag, 4);
            $display("row %0d tag=%0d stall=%0b full=%0b count=%0d o_tag=%0d",
                     i, vecs[i].tag, vecs[i].stall, full_seen, o_count, o_tag);
        end

        // Forwarding: newest matching entry wins, then the output register.
        step(8'd20, 5'd7, 32'h11, 1'b0, 1'b1, full_seen);
        step(8'd21, 5'd7, 32'h22, 1'b0, 1'b1, full_seen);
        step(8'd22, 5'd9, 32'h33, 1'b0, 1'b1, full_seen);
        check("fwd_fill_count", o_count, 3);
        fwd_check(5'd7, 1'b1, 32'h22);
        fwd_check(5'd9, 1'b1, 32'h33);
        fwd_check(5'd6, 1'b1, 32'h109);
        fwd_check(5'd12, 1'b0, 32'h0);
        fwd_check(5'd0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(8'd22, 5'd9, 32'h33, 1'b0, 1'b0, full_seen);
        check("fwd_drained_count", o_count, 0);
        fwd_check(5'd7, 1'b0, 32'h0);
        fwd_check(5'd9, 1'b1, 32'h33);

        // A tag held for many cycles is a single item.
        d0 = drains;
        for (int i = 0; i < 10; i++) step(8'd30, 5'd3, 32'h55, 1'b0, 1'b0, full_seen);
        check("held_tag_drains", drains - d0, 1);
        check("held_tag_count", o_count, 0);

        // Asynchronous reset with items pending.
        step(8'd40, 5'd1, 32'hA, 1'b0, 1'b1, full_seen);
        step(8'd41, 5'd2, 32'hB, 1'b0, 1'b1, full_seen);
        step(8'd42, 5'd3, 32'hC, 1'b0, 1'b1, full_seen);
        check("pre_reset_count", o_count, 3);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_reset_count", o_count, 0);
        check("async_reset_tag", o_tag, 0);
        check("async_reset_inst_rd", o_inst_rd, 0);
        check("async_reset_rd", o_rd, 0);
        check("async_reset_branch", o_branch, 0);
        check("async_reset_pc", o_pc_next, 0);
        $display("async reset count=%0d o_tag=%0d", o_count, o_tag);
        sb.delete();
        prev_tag = 8'd0;
        model_last_tag = 8'd0;
        i_tag = 8'd0;
        i_stall = 1'b0;
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        for (int i = 0; i < 3; i++) step(8'd0, 5'd0, 32'h0, 1'b0, 1'b0, full_seen);
        check("post_reset_count", o_count, 0);
        check("post_reset_tag", o_tag, 0);
        fwd_check(5'd3, 1'b0, 32'h0);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
